// File: rtl/pkt_ctrl_multi_pkg.sv
// Shared types for the multi-engine packet-transfer controller.
// The state encoding doubles as the externally visible state_out code.
package pkt_ctrl_pkg;

  localparam logic [2:0] STATE_OUT_IDLE  = 3'd0;
  localparam logic [2:0] STATE_OUT_RUN   = 3'd1;
  localparam logic [2:0] STATE_OUT_DONE  = 3'd2;
  localparam logic [2:0] STATE_OUT_ABORT = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = STATE_OUT_IDLE,
    ST_RUN   = STATE_OUT_RUN,
    ST_DONE  = STATE_OUT_DONE,
    ST_ABORT = STATE_OUT_ABORT
  } state_e;

endpackage

// File: rtl/pkt_ctrl_multi_if.sv
// Request/engine/status bundle between the capture front end and the controller.
// master = requester and engines side, slave = controller side.
interface pkt_ctrl_multi_if #(
  parameter int N_ENG = 2,
  parameter int CNT_W = 16
) ();

  logic             new_request;
  logic [N_ENG-1:0] req_mask;
  logic [N_ENG-1:0] eng_rdy;
  logic [N_ENG-1:0] eng_start;
  logic [2:0]       state_out;
  logic             busy;
  logic             idle;
  logic             done;
  logic             timeout;
  logic             pending;
  logic             dropped;
  logic [CNT_W-1:0] xfer_count;

  modport master (
    output new_request, req_mask, eng_rdy,
    input  eng_start, state_out, busy, idle, done, timeout, pending, dropped, xfer_count
  );

  modport slave (
    input  new_request, req_mask, eng_rdy,
    output eng_start, state_out, busy, idle, done, timeout, pending, dropped, xfer_count
  );

endinterface

// File: rtl/pkt_ctrl_multi_wdog.sv
// RUN-phase watchdog: clearable up-counter that flags the last permitted cycle.
// With TIMEOUT=0 the counter is not built and expiry never fires.
module pkt_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT > 0) begin : g_cnt
      localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
      logic [W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired_o = (cnt_q == LAST);
    end else begin : g_off
      logic unused_wdog;
      assign unused_wdog = ^{clk, reset, clr_i, en_i};
      assign expired_o   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pkt_ctrl_multi.sv
// Multi-engine transfer controller: launches the masked engines, gathers their
// completions in any order, and reports done/abort with a one-deep request queue.
module pkt_ctrl_multi
  import pkt_ctrl_pkg::*;
#(
  parameter int N_ENG   = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  pkt_ctrl_multi_if.slave   bus
);

  state_e           state_q, state_d;
  logic [N_ENG-1:0] mask_q, mask_d;
  logic [N_ENG-1:0] done_vec_q, done_vec_d;
  logic [N_ENG-1:0] qmask_q, qmask_d;
  logic [N_ENG-1:0] start_q, start_d;
  logic             pending_q, pending_d;
  logic             dropped_q, dropped_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             wdog_expired;
  logic [N_ENG-1:0] acc_mask;
  logic [N_ENG-1:0] merged;

  pkt_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (accept),
    .en_i      (state_q == ST_RUN),
    .expired_o (wdog_expired)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    done_vec_d = done_vec_q;
    qmask_d    = qmask_q;
    start_d    = '0;
    pending_d  = pending_q;
    dropped_d  = 1'b0;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    acc_mask   = pending_q ? qmask_q : bus.req_mask;
    merged     = done_vec_q | (bus.eng_rdy & mask_q);

    case (state_q)
      ST_IDLE: begin
        // A held request takes priority over a fresh strobe.
        if (pending_q || bus.new_request) begin
          accept     = 1'b1;
          mask_d     = acc_mask;
          done_vec_d = '0;
          timeout_d  = 1'b0;
          pending_d  = 1'b0;
          if (acc_mask == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            start_d = acc_mask;
          end
        end
      end
      ST_RUN: begin
        done_vec_d = merged;
        if (merged == mask_q) begin
          state_d = ST_DONE;
        end else if (wdog_expired) begin
          state_d   = ST_ABORT;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (bus.new_request && ((state_q != ST_IDLE) || pending_q)) begin
      if (pending_q) begin
        dropped_d = 1'b1;
      end else begin
        pending_d = 1'b1;
        qmask_d   = bus.req_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      done_vec_q <= '0;
      qmask_q    <= '0;
      start_q    <= '0;
      pending_q  <= 1'b0;
      dropped_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      done_vec_q <= done_vec_d;
      qmask_q    <= qmask_d;
      start_q    <= start_d;
      pending_q  <= pending_d;
      dropped_q  <= dropped_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.eng_start  = start_q;
  assign bus.state_out  = state_q;
  assign bus.busy       = (state_q == ST_RUN);
  assign bus.idle       = (state_q == ST_IDLE);
  assign bus.done       = (state_q == ST_DONE) || (state_q == ST_ABORT);
  assign bus.timeout    = timeout_q;
  assign bus.pending    = pending_q;
  assign bus.dropped    = dropped_q;
  assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_pkt_ctrl_multi.sv
// Directed bench for pkt_ctrl_multi (N_ENG=2, TIMEOUT=8) with a scoreboard
// monitor that pops expected starts and completions as the DUT presents them.
module tb_pkt_ctrl_multi;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pkt_ctrl_multi_if #(.N_ENG(2), .CNT_W(16)) bus ();

  pkt_ctrl_multi #(
    .N_ENG   (2),
    .TIMEOUT (8),
    .CNT_W   (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        abort;
    logic [15:0] cnt;
  } done_t;

  done_t       done_exp_q[$];
  logic [1:0]  start_exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] exp_cnt = '0;
  done_t       ed;
  logic [1:0]  es;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request(input logic [1:0] m);
    bus.new_request = 1'b1;
    bus.req_mask    = m;
    step(1);
    bus.new_request = 1'b0;
    bus.req_mask    = 2'b00;
  endtask

  task automatic expect_xfer(input logic [1:0] m, input logic abort);
    if (m != 2'b00) start_exp_q.push_back(m);
    done_exp_q.push_back({abort, exp_cnt});
    if (!abort) exp_cnt = exp_cnt + 16'd1;
  endtask

  // Monitor: every start pulse and every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.eng_start != 2'b00) begin
        if (start_exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_start: got %b, expected no start", bus.eng_start);
        end else begin
          es = start_exp_q.pop_front();
          chk("eng_start", 32'(bus.eng_start), 32'(es));
        end
      end
      if (bus.done) begin
        if (done_exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done=1, expected no done");
        end else begin
          ed = done_exp_q.pop_front();
          $display("xfer done: timeout=%0d xfer_count=%0d (exp timeout=%0d count=%0d)",
                   bus.timeout, bus.xfer_count, ed.abort, ed.cnt);
          chk("done_timeout", 32'(bus.timeout), 32'(ed.abort));
          chk("done_xfer_count", 32'(bus.xfer_count), 32'(ed.cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.new_request = 1'b0;
    bus.req_mask    = 2'b00;
    bus.eng_rdy     = 2'b00;
    step(3);
    chk("rst_idle", 32'(bus.idle), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_state", 32'(bus.state_out), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_xfer", 32'(bus.xfer_count), 0);
    chk("rst_outs", 32'({bus.pending, bus.dropped, bus.timeout, bus.eng_start}), 0);
    reset = 1'b1;
    step(2);

    // Staggered completions, rdy[0] at RUN+3, rdy[1] at RUN+7
    expect_xfer(2'b11, 1'b0);
    request(2'b11);
    chk("t1_run", 32'(bus.state_out), 1);
    chk("t1_start", 32'(bus.eng_start), 3);
    step(1);
    chk("t1_start_once", 32'(bus.eng_start), 0);
    step(2);
    bus.eng_rdy = 2'b01; step(1); bus.eng_rdy = 2'b00;
    chk("t1_busy", 32'(bus.busy), 1);
    step(3);
    bus.eng_rdy = 2'b10; step(1); bus.eng_rdy = 2'b00;
    chk("t1_done_state", 32'(bus.state_out), 2);
    step(1);
    chk("t1_idle", 32'(bus.idle), 1);
    chk("t1_xfer", 32'(bus.xfer_count), 1);

    // Simultaneous completion
    expect_xfer(2'b11, 1'b0);
    request(2'b11);
    step(2);
    bus.eng_rdy = 2'b11; step(1); bus.eng_rdy = 2'b00;
    chk("t2_done_state", 32'(bus.state_out), 2);
    step(1);

    // Out-of-mask rdy ignored, then zero mask
    expect_xfer(2'b01, 1'b0);
    request(2'b01);
    bus.eng_rdy = 2'b10; step(1); bus.eng_rdy = 2'b00;
    chk("t3_ignore_rdy", 32'(bus.state_out), 1);
    bus.eng_rdy = 2'b01; step(1); bus.eng_rdy = 2'b00;
    chk("t3_done_state", 32'(bus.state_out), 2);
    step(1);
    expect_xfer(2'b00, 1'b0);
    request(2'b00);
    chk("t3z_direct_done", 32'(bus.state_out), 2);
    chk("t3z_no_start", 32'(bus.eng_start), 0);
    step(1);
    chk("t3z_idle", 32'(bus.idle), 1);

    // Watchdog abort after 8 RUN cycles
    expect_xfer(2'b11, 1'b1);
    request(2'b11);
    step(7);
    chk("t4_still_run", 32'(bus.state_out), 1);
    step(1);
    chk("t4_abort_state", 32'(bus.state_out), 3);
    chk("t4_abort_done", 32'(bus.done), 1);
    chk("t4_abort_timeout", 32'(bus.timeout), 1);
    step(1);
    chk("t4_sticky", 32'(bus.timeout), 1);
    chk("t4_xfer_kept", 32'(bus.xfer_count), 32'(exp_cnt));
    expect_xfer(2'b01, 1'b0);
    request(2'b01);
    chk("t4_timeout_clr", 32'(bus.timeout), 0);
    bus.eng_rdy = 2'b01; step(1); bus.eng_rdy = 2'b00;
    chk("t4b_done_state", 32'(bus.state_out), 2);
    step(1);

    // Queue one request, drop the next, then launch the queued mask
    expect_xfer(2'b11, 1'b0);
    request(2'b11);
    step(1);
    expect_xfer(2'b10, 1'b0);
    bus.new_request = 1'b1; bus.req_mask = 2'b10;
    step(1);
    bus.new_request = 1'b0;
    chk("t5_pending", 32'(bus.pending), 1);
    chk("t5_no_drop", 32'(bus.dropped), 0);
    bus.new_request = 1'b1; bus.req_mask = 2'b01;
    step(1);
    bus.new_request = 1'b0; bus.req_mask = 2'b00;
    chk("t5_dropped", 32'(bus.dropped), 1);
    chk("t5_pending_kept", 32'(bus.pending), 1);
    step(1);
    chk("t5_drop_pulse", 32'(bus.dropped), 0);
    bus.eng_rdy = 2'b11; step(1); bus.eng_rdy = 2'b00;
    chk("t5_done_state", 32'(bus.state_out), 2);
    step(1);
    chk("t5_idle_pending", 32'({bus.idle, bus.pending}), 3);
    step(1);
    chk("t5_q_run", 32'(bus.state_out), 1);
    chk("t5_q_start", 32'(bus.eng_start), 2);
    chk("t5_q_pending_clr", 32'(bus.pending), 0);
    bus.eng_rdy = 2'b10; step(1); bus.eng_rdy = 2'b00;
    chk("t5_q_done_state", 32'(bus.state_out), 2);
    step(1);

    // Reset mid-RUN with a queued request
    start_exp_q.push_back(2'b11);
    request(2'b11);
    step(1);
    bus.new_request = 1'b1; bus.req_mask = 2'b01;
    step(1);
    bus.new_request = 1'b0; bus.req_mask = 2'b00;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    exp_cnt = '0;
    chk("t6_idle", 32'(bus.idle), 1);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_pending", 32'(bus.pending), 0);
    chk("t6_xfer", 32'(bus.xfer_count), 0);
    chk("t6_done", 32'(bus.done), 0);
    bus.eng_rdy = 2'b11; step(1); bus.eng_rdy = 2'b00;
    step(3);
    chk("t6_stay_idle", 32'(bus.state_out), 0);

    expect_xfer(2'b01, 1'b0);
    request(2'b01);
    bus.eng_rdy = 2'b01; step(1); bus.eng_rdy = 2'b00;
    step(1);
    chk("t7_xfer_restart", 32'(bus.xfer_count), 1);
    step(3);
    chk("sb_start_drained", 32'(start_exp_q.size()), 0);
    chk("sb_done_drained", 32'(done_exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
